// File: rtl/testdata_check_if.sv
// Read-path bus between the DDR3 test-data generator and its checker:
// read-phase enable, read-FIFO read enable and read-FIFO output data.
interface testdata_check_if #(
  parameter int DATA_WIDTH = 16
);
  logic                  start;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;

  modport master (output start, rd_en, rd_data);
  modport slave  (input  start, rd_en, rd_data);
endinterface

// File: rtl/testdata_check.sv
// Read-path checker: realigns rd_en to the FIFO read latency, compares each word
// against an incrementing pattern, and reports verdict, error statistics and watchdog status.
module testdata_check #(
  parameter int DATA_WIDTH = 16,
  parameter int START_VAL  = 0,
  parameter int TOTAL      = 1300,
  parameter int RD_LATENCY = 1,
  parameter int TIMEOUT    = 65535,
  parameter int ERR_CNT_W  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  testdata_check_if.slave       bus,
  output logic                  check_done,
  output logic                  check_pass,
  output logic [ERR_CNT_W-1:0]  err_cnt,
  output logic [15:0]           sample_cnt,
  output logic [15:0]           first_err_idx,
  output logic [DATA_WIDTH-1:0] first_err_exp,
  output logic [DATA_WIDTH-1:0] first_err_act,
  output logic                  timeout_flag,
  output logic                  overrun_flag
);

  localparam int WD_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [15:0]           LAST_IDX = 16'(TOTAL - 1);
  localparam logic [WD_W-1:0]       WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] EXP_INIT = DATA_WIDTH'(START_VAL);

  typedef enum logic [1:0] {IDLE, CHECK, PASS, FAIL} state_t;

  state_t                state, state_nxt;
  logic                  strobe;
  logic                  mismatch;
  logic                  last_sample;
  logic                  wd_hit;
  logic [WD_W-1:0]       wd_cnt;
  logic [DATA_WIDTH-1:0] expected;

  function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // Stage p0: rd_en delay line matching the FIFO read latency
  generate
    if (RD_LATENCY == 0) begin : g_fwft
      assign strobe = bus.rd_en;
    end else begin : g_dly
      logic [RD_LATENCY-1:0] vld_p0;
      always_ff @(posedge clk) begin
        if (rst) vld_p0 <= '0;
        else     vld_p0 <= (vld_p0 << 1) | RD_LATENCY'(bus.rd_en);
      end
      assign strobe = vld_p0[RD_LATENCY-1];
    end
  endgenerate

  assign mismatch    = strobe && (bus.rd_data != expected);
  assign last_sample = (sample_cnt == LAST_IDX);
  assign wd_hit      = (wd_cnt == WD_LAST);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (bus.start) state_nxt = CHECK;
      CHECK: begin
        // A strobe in the cycle the watchdog would expire takes priority
        if (strobe) begin
          if (last_sample)
            state_nxt = (err_cnt == '0 && !mismatch) ? PASS : FAIL;
        end else if (wd_hit) begin
          state_nxt = FAIL;
        end
      end
      PASS:  if (strobe) state_nxt = FAIL;
      FAIL:  state_nxt = FAIL;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: state, counters, first-error capture and sticky flags
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      check_done    <= 1'b0;
      check_pass    <= 1'b0;
      err_cnt       <= '0;
      sample_cnt    <= '0;
      first_err_idx <= '0;
      first_err_exp <= '0;
      first_err_act <= '0;
      timeout_flag  <= 1'b0;
      overrun_flag  <= 1'b0;
      wd_cnt        <= '0;
      expected      <= EXP_INIT;
    end else begin
      state      <= state_nxt;
      check_done <= (state_nxt == PASS) || (state_nxt == FAIL);
      check_pass <= (state_nxt == PASS);
      if (state == CHECK) begin
        if (strobe) begin
          wd_cnt     <= '0;
          sample_cnt <= sample_cnt + 16'd1;
          expected   <= expected + 1'b1;
          if (mismatch) begin
            err_cnt <= sat_inc(err_cnt);
            if (err_cnt == '0) begin
              first_err_idx <= sample_cnt;
              first_err_exp <= expected;
              first_err_act <= bus.rd_data;
            end
          end
        end else if (wd_hit) begin
          timeout_flag <= 1'b1;
        end else begin
          wd_cnt <= wd_cnt + 1'b1;
        end
      end
      if ((state == PASS || state == FAIL) && strobe)
        overrun_flag <= 1'b1;
    end
  end

endmodule

// File: tb/tb_testdata_check.sv
// Directed bench: four checker instances (latency 1, wrap-around, latency 0, latency 2)
// fed from one shared read stream, with rd_data modelled as a FIFO of matching latency.
module tb_testdata_check;

  logic clk = 1'b0;
  logic rst;
  logic start;
  logic rd_en;
  logic corrupt;
  logic [15:0] word, word_d1, word_d2;

  int n_assert = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    word_d1 <= word;
    word_d2 <= word_d1;
  end

  testdata_check_if #(.DATA_WIDTH(16)) bus_a ();
  testdata_check_if #(.DATA_WIDTH(16)) bus_b ();
  testdata_check_if #(.DATA_WIDTH(16)) bus_c ();
  testdata_check_if #(.DATA_WIDTH(16)) bus_d ();

  assign bus_a.start = start; assign bus_a.rd_en = rd_en; assign bus_a.rd_data = word_d1;
  assign bus_b.start = start; assign bus_b.rd_en = rd_en; assign bus_b.rd_data = word_d1 + 16'hFFFE;
  assign bus_c.start = start; assign bus_c.rd_en = rd_en; assign bus_c.rd_data = word;
  assign bus_d.start = start; assign bus_d.rd_en = rd_en; assign bus_d.rd_data = word_d2;

  logic        a_done, a_pass, a_to, a_ov;
  logic [15:0] a_err, a_cnt, a_fidx, a_fexp, a_fact;
  logic        b_done, b_pass, b_to, b_ov;
  logic [15:0] b_err, b_cnt, b_fidx, b_fexp, b_fact;
  logic        c_done, c_pass, c_to, c_ov;
  logic [15:0] c_err, c_cnt, c_fidx, c_fexp, c_fact;
  logic        d_done, d_pass, d_to, d_ov;
  logic [15:0] d_err, d_cnt, d_fidx, d_fexp, d_fact;

  testdata_check #(.RD_LATENCY(1), .TIMEOUT(100)) u_a (
    .clk(clk), .rst(rst), .bus(bus_a), .check_done(a_done), .check_pass(a_pass),
    .err_cnt(a_err), .sample_cnt(a_cnt), .first_err_idx(a_fidx), .first_err_exp(a_fexp),
    .first_err_act(a_fact), .timeout_flag(a_to), .overrun_flag(a_ov));

  testdata_check #(.START_VAL(16'hFFFE), .TOTAL(4), .RD_LATENCY(1)) u_b (
    .clk(clk), .rst(rst), .bus(bus_b), .check_done(b_done), .check_pass(b_pass),
    .err_cnt(b_err), .sample_cnt(b_cnt), .first_err_idx(b_fidx), .first_err_exp(b_fexp),
    .first_err_act(b_fact), .timeout_flag(b_to), .overrun_flag(b_ov));

  testdata_check #(.RD_LATENCY(0), .TIMEOUT(100)) u_c (
    .clk(clk), .rst(rst), .bus(bus_c), .check_done(c_done), .check_pass(c_pass),
    .err_cnt(c_err), .sample_cnt(c_cnt), .first_err_idx(c_fidx), .first_err_exp(c_fexp),
    .first_err_act(c_fact), .timeout_flag(c_to), .overrun_flag(c_ov));

  testdata_check #(.RD_LATENCY(2), .TIMEOUT(100)) u_d (
    .clk(clk), .rst(rst), .bus(bus_d), .check_done(d_done), .check_pass(d_pass),
    .err_cnt(d_err), .sample_cnt(d_cnt), .first_err_idx(d_fidx), .first_err_exp(d_fexp),
    .first_err_act(d_fact), .timeout_flag(d_to), .overrun_flag(d_ov));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Words lo..hi-1, with an idle cycle before every index = 3 mod 7.
  // Returns at the negedge following the last rd_en edge, with rd_en low.
  task automatic send(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      if (i % 7 == 3) begin
        rd_en = 1'b0;
        word  = 16'h5A5A;
        @(negedge clk);
      end
      rd_en = 1'b1;
      word  = 16'(i);
      if (corrupt && i == 500) word = 16'hBEEF;
      if (corrupt && i == 900) word = 16'(i) ^ 16'h0001;
    end
    @(negedge clk);
    rd_en = 1'b0;
    word  = 16'h5A5A;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst   = 1'b1;
    rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_pass_all(input string tag);
    check({tag, " a_pass"}, {30'd0, a_done, a_pass}, 32'h3);
    check({tag, " a_cnt"},  a_cnt, 32'd1300);
    check({tag, " a_err"},  a_err, 32'd0);
    check({tag, " a_flags"}, {30'd0, a_to, a_ov}, 32'h0);
    check({tag, " c_pass"}, {30'd0, c_done, c_pass}, 32'h3);
    check({tag, " c_cnt"},  c_cnt, 32'd1300);
    check({tag, " d_pass"}, {30'd0, d_done, d_pass}, 32'h3);
    check({tag, " d_cnt"},  d_cnt, 32'd1300);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; rd_en = 1'b0; corrupt = 1'b0; word = 16'h0;
    repeat (3) @(negedge clk);
    check("reset a_status", {a_done, a_pass, a_to, a_ov}, 32'h0);
    check("reset a_cnt", a_cnt, 32'd0);
    check("reset a_err", a_err, 32'd0);
    check("reset a_fidx", a_fidx, 32'd0);
    rst = 1'b0;

    // Strobes while IDLE are ignored
    send(0, 3);
    repeat (3) @(negedge clk);
    check("idle a_cnt", a_cnt, 32'd0);
    check("idle d_cnt", d_cnt, 32'd0);
    check("idle a_done", a_done, 32'd0);

    // Clean stream; B (TOTAL=4, START_VAL=FFFE) verdict after the first 4 words
    start = 1'b1;
    @(negedge clk);
    send(0, 4);
    repeat (2) @(negedge clk);
    check("wrap b_pass", {30'd0, b_done, b_pass}, 32'h3);
    check("wrap b_cnt", b_cnt, 32'd4);
    check("wrap b_err", b_err, 32'd0);
    check("wrap a_cnt", a_cnt, 32'd4);
    send(4, 1300);
    repeat (4) @(negedge clk);
    check_pass_all("clean");
    check("clean b_ov", b_ov, 32'd1);
    check("clean b_cnt", b_cnt, 32'd4);

    // Extra word after PASS
    send(1300, 1301);
    repeat (4) @(negedge clk);
    check("overrun a_ov", a_ov, 32'd1);
    check("overrun a_pass", {30'd0, a_done, a_pass}, 32'h2);
    check("overrun a_cnt", a_cnt, 32'd1300);
    check("overrun d_ov", d_ov, 32'd1);

    // Corrupted words 500 and 900
    do_reset();
    corrupt = 1'b1;
    send(0, 1300);
    corrupt = 1'b0;
    repeat (4) @(negedge clk);
    check("err a_verdict", {30'd0, a_done, a_pass}, 32'h2);
    check("err a_err", a_err, 32'd2);
    check("err a_fidx", a_fidx, 32'd500);
    check("err a_fexp", a_fexp, 32'd500);
    check("err a_fact", a_fact, 32'hBEEF);
    check("err a_cnt", a_cnt, 32'd1300);
    check("err c_err", c_err, 32'd2);
    check("err d_fact", d_fact, 32'hBEEF);

    // Reset mid-check, then a fresh stream
    do_reset();
    send(0, 700);
    rst = 1'b1;
    @(negedge clk);
    check("midrst a_status", {a_done, a_pass, a_to, a_ov}, 32'h0);
    check("midrst a_cnt", a_cnt, 32'd0);
    check("midrst a_err", a_err, 32'd0);
    check("midrst d_cnt", d_cnt, 32'd0);
    rst = 1'b0;
    send(0, 1300);
    repeat (4) @(negedge clk);
    check_pass_all("rerun");

    // Watchdog: 10 words then silence, start dropped
    do_reset();
    send(0, 10);
    start = 1'b0;
    repeat (100) @(negedge clk);
    check("wd a_before", {a_done, a_to}, 32'h0);
    check("wd c_expired", {c_done, c_to}, 32'h3);
    check("wd d_before", d_done, 32'd0);
    @(negedge clk);
    check("wd a_expired", {a_done, a_pass, a_to}, 32'h5);
    check("wd a_cnt", a_cnt, 32'd10);
    check("wd a_err", a_err, 32'd0);
    @(negedge clk);
    check("wd d_expired", {d_done, d_to}, 32'h3);
    check("wd d_cnt", d_cnt, 32'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/testdata_check.md
Name: testdata_check

Overview:
- Downstream consumer of the DDR3 test-data generator's read path.
- Watches the generator's read-FIFO read enable and the read-FIFO output data, and realigns the enable to the FIFO read latency.
- Checks each returned word against the expected incrementing pattern and reports pass/fail, error count, first-error capture and timeout/overrun status for LEDs or ILA.

Parameters:
DATA_WIDTH, 16, width of test words
START_VAL, 0, first expected word
TOTAL, 1300, number of words that must be checked
RD_LATENCY, 1, cycles from rd_en to valid rd_data (legal 0..4; 0 = FWFT FIFO)
TIMEOUT, 65535, max idle cycles between samples while checking
ERR_CNT_W, 16, error counter width

Ports:
clk  in  1  system clock, same as FIFO clock
rst  in  1  synchronous reset, active-high
start  in  1  level; high = read phase enabled (driven by rd_mem_enable)
rd_en  in  1  read-FIFO read enable issued upstream
rd_data  in  DATA_WIDTH  read-FIFO output data
check_done  out  1  high in PASS or FAIL
check_pass  out  1  high only in PASS
err_cnt  out  ERR_CNT_W  saturating mismatch count
sample_cnt  out  16  words checked so far
first_err_idx  out  16  sample index of first mismatch
first_err_exp  out  DATA_WIDTH  expected value at first mismatch
first_err_act  out  DATA_WIDTH  received value at first mismatch
timeout_flag  out  1  sticky; idle watchdog expired
overrun_flag  out  1  sticky; sample arrived after TOTAL reached

Behaviour:
- rst sampled on rising clk only. All outputs, counters, the delay line and the state reset to 0 (state IDLE). Expected value resets to START_VAL.
- Reset asserted mid-check clears everything on that edge. Samples in flight in the delay line are discarded.
- Sample strobe: rd_en delayed by RD_LATENCY registers (combinational when 0). rd_data is sampled in the cycle the strobe is high.
- IDLE:
  - start=1 -> CHECK on next edge.
  - Strobes in IDLE are ignored and not counted.
- CHECK, on each strobe:
  - compare rd_data with the expected value;
  - sample_cnt+1;
  - expected+1, wrapping modulo 2^DATA_WIDTH.
- Mismatch handling:
  - err_cnt+1, saturating at all-ones.
  - If err_cnt was 0, capture first_err_idx = sample_cnt (pre-increment), first_err_exp and first_err_act. Capture registers are written once only.
- Completion: when the TOTAL-th sample is processed, the next state is PASS if err_cnt (including the current compare) is 0, otherwise FAIL.
- Watchdog:
  - Counts cycles in CHECK without a strobe and clears to 0 on every strobe.
  - Reaching TIMEOUT -> timeout_flag=1, go to FAIL.
  - A strobe in the same cycle the count would hit TIMEOUT wins: the count clears and no timeout occurs.
- PASS / FAIL:
  - Terminal until rst; start deassertion has no effect.
  - Any strobe sets overrun_flag; PASS additionally moves to FAIL. Data is not compared and counters are frozen.
- check_done = state is PASS or FAIL. check_pass = state is PASS. Both are registered and update on the edge the state changes.
- Latency: a strobe at edge N is reflected in sample_cnt/err_cnt after edge N. Final verdict is visible on the edge that processes sample TOTAL.
- start dropping during CHECK does not pause checking; the watchdog still runs.

Test Plan:
- RD_LATENCY=1; start=1; 1300 rd_en pulses with rd_data 0..1299 one cycle after each -> check_pass=1, err_cnt=0, sample_cnt=1300, flags 0.
- Same stream with word 500 replaced by 0xBEEF, and word 900 corrupted -> FAIL; err_cnt=2; first_err_idx=500, first_err_exp=500, first_err_act=0xBEEF.
- START_VAL=0xFFFE, TOTAL=4; data FFFE,FFFF,0000,0001 -> PASS, proving wrap-around.
- TIMEOUT=100; send 10 correct words, then stop -> timeout_flag=1 and FAIL exactly 100 cycles after the last strobe; sample_cnt=10.
- After PASS, issue one more rd_en -> overrun_flag=1, check_pass=0, sample_cnt stays 1300.
- Assert rst for 1 cycle at sample 700 -> all outputs 0 next edge. Rerun with RD_LATENCY=0 and 2 -> PASS.
